// File: rtl/obw_bus_arbiter.sv
// Round-robin owner sequencer for a shared tristate pad bank.
// One requester at a time drives the bus; every hand-over, including a hand-back
// to the same requester, first releases the bus for TURN_CYC cycles.
module obw_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*WIDTH-1:0]    din_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [$clog2(NREQ)-1:0]  owner_o,
    output logic [WIDTH-1:0]         bus_i_o,
    output logic [WIDTH-1:0]         bus_t_o,
    output logic                     busy_o
);
    localparam int OW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN_CYC + 1);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [TW-1:0]   turn_q, turn_d;
    logic [WIDTH-1:0] bus_i_q, bus_i_d;

    logic            win_vld;
    logic [OW-1:0]   win_idx;
    logic [NREQ-1:0] own_mask;
    logic            others;

    assign own_mask = NREQ'(1) << owner_q;
    assign others   = |(req_i & ~own_mask);

    // Pick the first active request at or after the round-robin pointer.
    always_comb begin
        int k;
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr_q) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!win_vld && req_i[k]) begin
                win_vld = 1'b1;
                win_idx = OW'(k);
            end
        end
    end

    // State and datapath registers; reset overrides every transition.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
            bus_i_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            bus_i_q <= bus_i_d;
        end
    end

    // Next-state: grant, hold accounting, release and turnaround countdown.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        bus_i_d = bus_i_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = GRANT;
                    owner_d = win_idx;
                    hold_d  = HW'(1);
                    bus_i_d = din_i[win_idx*WIDTH +: WIDTH];
                end
            end
            GRANT: begin
                if (!req_i[owner_q] || (hold_q == HW'(MAX_HOLD) && others)) begin
                    // Release: data holds its last value, pointer moves past owner.
                    state_d = TURN;
                    turn_d  = TW'(TURN_CYC);
                    hold_d  = '0;
                    ptr_d   = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);
                end else begin
                    bus_i_d = din_i[owner_q*WIDTH +: WIDTH];
                    hold_d  = (hold_q == HW'(MAX_HOLD)) ? HW'(1) : hold_q + HW'(1);
                end
            end
            TURN: begin
                turn_d = turn_q - TW'(1);
                if (turn_q == TW'(1)) begin
                    if (win_vld) begin
                        state_d = GRANT;
                        owner_d = win_idx;
                        hold_d  = HW'(1);
                        bus_i_d = din_i[win_idx*WIDTH +: WIDTH];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from registers only, so REQ/DIN never reach the pads combinationally.
    always_comb begin
        gnt_o   = (state_q == GRANT) ? own_mask : '0;
        owner_o = owner_q;
        bus_i_o = bus_i_q;
        bus_t_o = {WIDTH{state_q != GRANT}};
        busy_o  = (state_q != IDLE);
    end

endmodule

// File: tb/tb_obw_bus_arbiter.sv
// Bench for obw_bus_arbiter: two instances (TURN_CYC=1/MAX_HOLD=16 and
// TURN_CYC=3/MAX_HOLD=5) share stimulus and are compared to a transaction model.
module tb_obw_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] din = '0;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] own_a, own_b;
    logic [7:0] bi_a, bi_b, bt_a, bt_b;
    logic       busy_a, busy_b;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    obw_bus_arbiter #(.NREQ(4), .WIDTH(8), .TURN_CYC(1), .MAX_HOLD(16)) u_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .din_i(din),
        .gnt_o(gnt_a), .owner_o(own_a), .bus_i_o(bi_a), .bus_t_o(bt_a), .busy_o(busy_a));

    obw_bus_arbiter #(.NREQ(4), .WIDTH(8), .TURN_CYC(3), .MAX_HOLD(5)) u_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .din_i(din),
        .gnt_o(gnt_b), .owner_o(own_b), .bus_i_o(bi_b), .bus_t_o(bt_b), .busy_o(busy_b));

    // Model: who owns the bus (-1 none), last owner, cycles held, release cycles left.
    typedef struct {
        int own; int last; int hold; int tl; int ptr; logic [7:0] bi;
    } mst_t;

    mst_t ma, mb;

    function automatic mst_t step(mst_t m, logic r, logic [3:0] q, logic [31:0] d, int tc, int mh);
        mst_t n;
        int   w;
        logic oth;
        n = m;
        if (r) begin
            n.own = -1; n.last = 0; n.hold = 0; n.tl = 0; n.ptr = 0; n.bi = '0;
            return n;
        end
        w = -1;
        for (int i = 0; i < 4; i++)
            if (w < 0 && q[(m.ptr + i) % 4]) w = (m.ptr + i) % 4;
        if (m.own >= 0) begin
            oth = (q & ~(4'b0001 << m.own)) != 4'b0000;
            if (!q[m.own] || (m.hold == mh && oth)) begin
                n.own = -1; n.tl = tc; n.ptr = (m.own + 1) % 4;
            end else begin
                n.bi   = d[m.own*8 +: 8];
                n.hold = (m.hold == mh) ? 1 : m.hold + 1;
            end
        end else if (m.tl > 0) begin
            n.tl = m.tl - 1;
            if (n.tl == 0 && w >= 0) begin
                n.own = w; n.last = w; n.hold = 1; n.bi = d[w*8 +: 8];
            end
        end else if (w >= 0) begin
            n.own = w; n.last = w; n.hold = 1; n.bi = d[w*8 +: 8];
        end
        return n;
    endfunction

    // {gnt, owner, bus_i, bus_t, busy} the model expects to see.
    function automatic logic [22:0] exp_of(mst_t m);
        logic [3:0] g;
        g = (m.own >= 0) ? 4'(1 << m.own) : 4'b0000;
        return {g, 2'(m.last), m.bi, (m.own >= 0) ? 8'h00 : 8'hFF, (m.own >= 0) || (m.tl > 0)};
    endfunction

    wire [22:0] obs_a = {gnt_a, own_a, bi_a, bt_a, busy_a};
    wire [22:0] obs_b = {gnt_b, own_b, bi_b, bt_b, busy_b};

    // Advance the model on the same edge the DUTs sample their inputs.
    always @(posedge clk) begin
        ma = step(ma, rst, req, din, 1, 16);
        mb = step(mb, rst, req, din, 3, 5);
    end

    // Bus-safety invariants on both instances, sampled mid-cycle.
    logic [1:0][3:0] gg;
    logic [1:0][7:0] tt;
    assign gg = {gnt_b, gnt_a};
    assign tt = {bt_b, bt_a};
    int   gap [2] = '{1000, 1000};
    logic [3:0] pg [2] = '{4'b0, 4'b0};
    logic prst = 1'b1;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                total++;
                if ($countones(gg[d]) > 1) begin
                    bad++; $display("FAIL inv_onehot dut%0d gnt=%b required=onehot-or-zero", d, gg[d]);
                end
                total++;
                if (tt[d] != 8'h00 && tt[d] != 8'hFF) begin
                    bad++; $display("FAIL inv_t_equal dut%0d bus_t=%h required=00/FF", d, tt[d]);
                end
                total++;
                if ((tt[d] == 8'h00) != (gg[d] != 4'b0)) begin
                    bad++; $display("FAIL inv_t_vs_gnt dut%0d bus_t=%h gnt=%b", d, tt[d], gg[d]);
                end
                if (prst) gap[d] = 1000;
                if (gg[d] == 4'b0) begin
                    gap[d] = (pg[d] != 4'b0 && !prst) ? 1 : gap[d] + 1;
                end else if (pg[d] == 4'b0) begin
                    total++;
                    if (gap[d] < (d == 0 ? 1 : 3)) begin
                        bad++; $display("FAIL inv_gap dut%0d gap=%0d required>=%0d", d, gap[d], (d == 0 ? 1 : 3));
                    end
                end else begin
                    total++;
                    if (gg[d] != pg[d]) begin
                        bad++; $display("FAIL inv_switch dut%0d gnt %b->%b without release", d, pg[d], gg[d]);
                    end
                end
                pg[d] = gg[d];
            end
        end
        prst = rst;
    end

    task automatic test_reset();
        rst = 1'b1; req = 4'($urandom); din = $urandom;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk_en = 1'b1;
            total++;
            if (obs_a !== {4'b0000, 2'd0, 8'h00, 8'hFF, 1'b0}) begin
                bad++; $display("FAIL reset_a got=%h required=%h", obs_a, {4'b0000, 2'd0, 8'h00, 8'hFF, 1'b0});
            end
            total++;
            if (obs_b !== exp_of(mb)) begin
                bad++; $display("FAIL reset_b got=%h required=%h", obs_b, exp_of(mb));
            end
        end
    endtask

    task automatic test_single();
        rst = 1'b1; @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; req = 4'b0001; din = 32'h0000_00A5;
        @(posedge clk); #1;
        total++;
        if ({gnt_a, bt_a, bi_a} !== {4'b0001, 8'h00, 8'hA5}) begin
            bad++; $display("FAIL single_grant got=%b/%h/%h required=0001/00/a5", gnt_a, bt_a, bi_a);
        end
        req = 4'b0000;
        @(posedge clk); #1;
        total++;
        if ({gnt_a, bt_a, bi_a, busy_a} !== {4'b0000, 8'hFF, 8'hA5, 1'b1}) begin
            bad++; $display("FAIL single_turn got=%b/%h/%h/%b required=0000/ff/a5/1", gnt_a, bt_a, bi_a, busy_a);
        end
        @(posedge clk); #1;
        total++;
        if ({gnt_a, bt_a, busy_a} !== {4'b0000, 8'hFF, 1'b0}) begin
            bad++; $display("FAIL single_idle got=%b/%h/%b required=0000/ff/0", gnt_a, bt_a, busy_a);
        end
        total++;
        if (obs_b !== exp_of(mb)) begin
            bad++; $display("FAIL single_b got=%h required=%h", obs_b, exp_of(mb));
        end
    endtask

    task automatic test_round_robin();
        int rise_own [$];
        int rise_cyc [$];
        logic [3:0] prev;
        rst = 1'b1; @(posedge clk); #1;
        rst = 1'b0; req = 4'b1111; prev = 4'b0;
        for (int c = 1; c <= 90; c++) begin
            din = $urandom;
            @(posedge clk); #1;
            if (gnt_a != 4'b0 && prev == 4'b0) begin
                rise_own.push_back(int'(own_a)); rise_cyc.push_back(c);
            end
            prev = gnt_a;
            total++;
            if (obs_a !== exp_of(ma)) begin
                bad++; $display("FAIL rr_model_a cyc=%0d got=%h required=%h", c, obs_a, exp_of(ma));
            end
            total++;
            if (obs_b !== exp_of(mb)) begin
                bad++; $display("FAIL rr_model_b cyc=%0d got=%h required=%h", c, obs_b, exp_of(mb));
            end
        end
        // 16 granted cycles plus one released cycle per owner: rises at 1, 18, 35, 52, 69.
        for (int k = 0; k < 5; k++) begin
            total++;
            if (k >= rise_own.size() || rise_own[k] != k % 4 || rise_cyc[k] != 1 + 17 * k) begin
                bad++;
                $display("FAIL rr_order k=%0d got owner=%0d cyc=%0d required owner=%0d cyc=%0d", k,
                         (k < rise_own.size()) ? rise_own[k] : -1, (k < rise_cyc.size()) ? rise_cyc[k] : -1,
                         k % 4, 1 + 17 * k);
            end
        end
    endtask

    task automatic test_no_contention();
        rst = 1'b1; @(posedge clk); #1;
        rst = 1'b0; req = 4'b0100;
        for (int c = 0; c < 40; c++) begin
            din = $urandom;
            @(posedge clk); #1;
            total++;
            if ({gnt_a, bt_a, gnt_b, bt_b} !== {4'b0100, 8'h00, 4'b0100, 8'h00}) begin
                bad++; $display("FAIL nocont cyc=%0d got a=%b/%h b=%b/%h required 0100/00", c, gnt_a, bt_a, gnt_b, bt_b);
            end
            total++;
            if (obs_b !== exp_of(mb)) begin
                bad++; $display("FAIL nocont_model_b cyc=%0d got=%h required=%h", c, obs_b, exp_of(mb));
            end
        end
    endtask

    task automatic test_turnaround();
        rst = 1'b1; @(posedge clk); #1;
        rst = 1'b0; req = 4'b0010; din = $urandom;
        @(posedge clk); #1;
        total++;
        if (gnt_b !== 4'b0010) begin
            bad++; $display("FAIL turn_start got=%b required=0010", gnt_b);
        end
        req = 4'b0110; @(posedge clk); #1;
        req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if ({gnt_b, bt_b} !== {4'b0000, 8'hFF}) begin
                bad++; $display("FAIL turn_gap c=%0d got=%b/%h required=0000/ff", c, gnt_b, bt_b);
            end
        end
        @(posedge clk); #1;
        total++;
        if ({gnt_b, bt_b} !== {4'b0100, 8'h00}) begin
            bad++; $display("FAIL turn_next got=%b/%h required=0100/00", gnt_b, bt_b);
        end
        total++;
        if (obs_a !== exp_of(ma)) begin
            bad++; $display("FAIL turn_model_a got=%h required=%h", obs_a, exp_of(ma));
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; @(posedge clk); #1;
        rst = 1'b0; req = 4'b0010; din = 32'h0000_3C00;
        @(posedge clk); #1;
        total++;
        if ({gnt_a, bi_a} !== {4'b0010, 8'h3C}) begin
            bad++; $display("FAIL rmid_grant got=%b/%h required=0010/3c", gnt_a, bi_a);
        end
        rst = 1'b1; @(posedge clk); #1;
        total++;
        if ({gnt_a, bt_a, bi_a, gnt_b, bt_b, bi_b} !== {4'b0000, 8'hFF, 8'h00, 4'b0000, 8'hFF, 8'h00}) begin
            bad++; $display("FAIL rmid_reset got a=%b/%h/%h b=%b/%h/%h required 0000/ff/00", gnt_a, bt_a, bi_a, gnt_b, bt_b, bi_b);
        end
        rst = 1'b0; req = 4'b1010;
        @(posedge clk); #1;
        total++;
        if ({gnt_a, gnt_b} !== {4'b0010, 4'b0010}) begin
            bad++; $display("FAIL rmid_ptr got a=%b b=%b required 0010", gnt_a, gnt_b);
        end
    endtask

    task automatic test_random();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) req = 4'($urandom);
            else if ($urandom_range(0, 5) == 0) req[$urandom_range(0, 3)] = ~req[$urandom_range(0, 3)];
            rst = ($urandom_range(0, 299) == 0);
            din = $urandom;
            @(posedge clk); #1;
            total++;
            if (obs_a !== exp_of(ma)) begin
                bad++; $display("FAIL rand_model_a cyc=%0d got=%h required=%h", c, obs_a, exp_of(ma));
            end
            total++;
            if (obs_b !== exp_of(mb)) begin
                bad++; $display("FAIL rand_model_b cyc=%0d got=%h required=%h", c, obs_b, exp_of(mb));
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_no_contention();
        test_turnaround();
        test_reset_mid();
        test_random();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
